// File: rtl/vga_frame_scaler.sv
// Raster-to-framebuffer mapper: scaled, double-buffered read address generation
// and fixed-latency pixel realignment. Optional colour bars: VGA_FRAME_TEST_PATTERN_EN.
module vga_frame_scaler #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned SCALE_LOG2 = 2,
  parameter int unsigned FB_W       = 160,
  parameter int unsigned FB_H       = 120,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned MEM_LAT    = 1,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [10:0]       vga_h,
  input  logic [10:0]       vga_v,
  input  logic [23:0]       mem_data,
  input  logic              swap_req,
`ifdef VGA_FRAME_TEST_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic [ADDR_W-1:0] read_address,
  output logic [ADDR_W-1:0] pixel_number,
  output logic [23:0]       pixel_out,
  output logic              pixel_valid,
  output logic              buf_sel,
  output logic              swap_ack
);

  localparam logic [10:0]       H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0]       V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0]       FB_W_C   = 11'(FB_W);
  localparam logic [10:0]       FB_H_C   = 11'(FB_H);
  localparam logic [ADDR_W-1:0] BUF_BASE = ADDR_W'(FB_W * FB_H);

  typedef enum logic {IDLE, PENDING} swap_state_t;

  // ---------------- stage 0: registered raster coordinates ----------------
  logic [10:0] s0_h, s0_v, prev_v;
  logic        s0_vld;

  // NOTE: every clocked block uses non-blocking assignments so all registers
  // sample pre-edge values and the pipeline stages do not race each other.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s0_h   <= '0;
      s0_v   <= '0;
      prev_v <= '0;
      s0_vld <= 1'b0;
    end else begin
      s0_h   <= vga_h;
      s0_v   <= vga_v;
      prev_v <= s0_v;
      s0_vld <= 1'b1;
    end
  end

  logic [10:0]       fb_x, fb_y;
  logic              s0_active, s0_win, vblank_start;
  logic [ADDR_W-1:0] pn_next;

  assign fb_x         = s0_h >> SCALE_LOG2;
  assign fb_y         = s0_v >> SCALE_LOG2;
  assign s0_active    = s0_vld && (s0_h < H_ACT) && (s0_v < V_ACT);
  assign s0_win       = s0_active && (fb_x < FB_W_C) && (fb_y < FB_H_C);
  // Edge detect so a raster that jumps straight onto V_ACTIVE still counts once.
  assign vblank_start = (s0_v == V_ACT) && (prev_v != V_ACT);
  assign pn_next      = s0_win ? (ADDR_W'(fb_y) * ADDR_W'(FB_W) + ADDR_W'(fb_x)) : '0;

  // ---------------- stage 1: address generation ----------------
  logic s1_active, s1_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_number <= '0;
      read_address <= '0;
      s1_active    <= 1'b0;
      s1_win       <= 1'b0;
    end else begin
      pixel_number <= pn_next;
      read_address <= pn_next + (buf_sel ? BUF_BASE : '0);
      s1_active    <= s0_active;
      s1_win       <= s0_win;
    end
  end

  // ---------------- flags ride alongside the RAM access ----------------
  logic [MEM_LAT-1:0] act_dly, win_dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_dly <= '0;
      win_dly <= '0;
    end else begin
      act_dly[0] <= s1_active;
      win_dly[0] <= s1_win;
      for (int i = 1; i < MEM_LAT; i++) begin
        act_dly[i] <= act_dly[i-1];
        win_dly[i] <= win_dly[i-1];
      end
    end
  end

`ifdef VGA_FRAME_TEST_PATTERN_EN
  // Bar index travels with the pixel so it lines up with the output stage.
  logic [2:0] s1_bar;
  logic [2:0] bar_dly [MEM_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_bar <= '0;
      for (int i = 0; i < MEM_LAT; i++) bar_dly[i] <= '0;
    end else begin
      s1_bar     <= 3'((32'(fb_x) * 32'd8) / 32'(FB_W));
      bar_dly[0] <= s1_bar;
      for (int i = 1; i < MEM_LAT; i++) bar_dly[i] <= bar_dly[i-1];
    end
  end

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  endfunction
`endif

  // ---------------- output stage ----------------
  logic [23:0] pix_next;

  // NOTE: pix_next gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pix_next = 24'h0;
    if (win_dly[MEM_LAT-1]) begin
      pix_next = mem_data;
`ifdef VGA_FRAME_TEST_PATTERN_EN
      if (test_mode) pix_next = bar_rgb(bar_dly[MEM_LAT-1]);
`endif
    end else if (act_dly[MEM_LAT-1]) begin
      pix_next = BORDER_RGB;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_out   <= pix_next;
      pixel_valid <= win_dly[MEM_LAT-1];
    end
  end

  // ---------------- buffer swap FSM ----------------
  swap_state_t state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      buf_sel  <= 1'b0;
      swap_ack <= 1'b0;
    end else begin
      swap_ack <= 1'b0;
      case (state)
        IDLE:    if (swap_req) state <= PENDING;
        PENDING: if (vblank_start) begin
          state    <= IDLE;
          buf_sel  <= ~buf_sel;
          swap_ack <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vga_frame_scaler.md
# vga_frame_scaler

Parametrised successor to `vga_frame`. Maps the VGA timing generator's raster coordinates onto a scaled, double-buffered framebuffer and generates the read address. It then realigns the memory's read data with a fixed, known pipeline latency. It sits between the VGA sync counter and the framebuffer RAM read port, and feeds 24-bit RGB to the DAC/output stage.

## Interface
- `H_ACTIVE`, 640: active pixels per line.
- `V_ACTIVE`, 480: active lines per frame.
- `SCALE_LOG2`, 2: each framebuffer pixel covers 2^SCALE_LOG2 × 2^SCALE_LOG2 screen pixels.
- `FB_W`, 160: framebuffer width in pixels.
- `FB_H`, 120: framebuffer height in pixels.
- `ADDR_W`, 16: address width. Requires 2·FB_W·FB_H ≤ 2^ADDR_W.
- `MEM_LAT`, 1: RAM read latency in cycles, ≥1.
- `BORDER_RGB`, 24'h000000: colour for active pixels outside the framebuffer window.

Ports:
- `clk` in 1: pixel clock.
- `reset` in 1: asynchronous, active-high.
- `vga_h` in 11: horizontal raster coordinate.
- `vga_v` in 11: vertical raster coordinate.
- `mem_data` in 24: RAM read data, valid MEM_LAT cycles after `read_address`.
- `swap_req` in 1: request a buffer swap; one-cycle pulse.
- `read_address` out ADDR_W: RAM read address, including buffer base.
- `pixel_number` out ADDR_W: framebuffer pixel index, without buffer base.
- `pixel_out` out 24: RGB pixel aligned to the output pipeline.
- `pixel_valid` out 1: `pixel_out` comes from the framebuffer window.
- `buf_sel` out 1: buffer currently displayed.
- `swap_ack` out 1: one-cycle pulse when a swap takes effect.

## Operation
- **Stage 0** registers `vga_h`, `vga_v`. It computes:
  - `active` = h<H_ACTIVE && v<V_ACTIVE
  - `win` = active && (h>>SCALE_LOG2)<FB_W && (v>>SCALE_LOG2)<FB_H
- **Stage 1**:
  - `pixel_number` = fb_y·FB_W + fb_x, truncated to ADDR_W. It is 0 when `win`=0.
  - `read_address` = `pixel_number` + (`buf_sel` ? FB_W·FB_H : 0).
  - Outside the window, `read_address` = buffer base.
- `active` and `win` are delayed MEM_LAT cycles alongside the RAM access.
- **Output stage** registers `pixel_out`:
  - `mem_data` if `win`
  - BORDER_RGB if `active` && !`win`
  - 24'h0 in blanking

  `pixel_valid` = delayed `win`.
- **Swap FSM** has states IDLE, PENDING.
  - IDLE → PENDING on `swap_req`=1.
  - PENDING → IDLE on a `vblank_start` event. On that transition, `buf_sel` toggles and `swap_ack` pulses for 1 cycle.
  - `vblank_start` = stage-0 v equals V_ACTIVE while the previous stage-0 v did not. Edge-detected, so non-sequential coordinate jumps are tolerated.
  - `swap_req` while PENDING is ignored (merged). `swap_req` coincident with `vblank_start` in IDLE enters PENDING and swaps at the next vblank.
- The new `buf_sel` applies to coordinates reaching stage 1 after the toggle cycle. A frame never mixes buffers.

## Timing
- Coordinates presented at cycle N produce:
  - `read_address`/`pixel_number` valid at N+2
  - `mem_data` expected at N+2+MEM_LAT
  - `pixel_out`/`pixel_valid` at N+3+MEM_LAT

  Total latency is 3+MEM_LAT; the sync generator must delay hsync/vsync by the same amount.
- Throughput is one pixel per cycle with no stalls.
- `swap_ack` asserts 2 cycles after `vga_v` first equals V_ACTIVE at the input.
- Reset, asynchronous, mid-operation:
  - All outputs → 0, `buf_sel`=0, FSM → IDLE. A pending swap is discarded with no ack.
  - Pipeline valid flags clear.
  - `previous v` → 0.

## Configuration
- `VGA_FRAME_TEST_PATTERN_EN` defined:
  - Adds input `test_mode` (1 bit).
  - When `test_mode`=1 and `win`, `pixel_out` = colour bar (fb_x·8)/FB_W. The bars in order are white, yellow, cyan, green, magenta, red, blue, black.
  - `mem_data` is ignored. Latency and address generation are unchanged.
- Undefined: no `test_mode` port; `pixel_out` is always from `mem_data`/border/blank.

## Test plan
All scenarios use default parameters.
1. Reset asserted, then released with coordinates held at 0 → all outputs 0, `buf_sel`=0, `swap_ack` never pulses.
2. Single pixel:
   - Stimulus: h=5, v=0 at cycle N.
   - Required: `read_address`=1 at N+2.
   - Drive `mem_data`=24'hABCDEF at N+3 → `pixel_out`=ABCDEF, `pixel_valid`=1 at N+4.
3. Coordinate mapping:
   - h=17, v=10 → `pixel_number`=`read_address`=324.
   - h=639, v=479 → 19199.
4. Blanking: h=800, v=1 → `pixel_valid`=0, `pixel_out`=0 at +4.
5. Buffer swap:
   - `swap_req` pulse at v=100, second pulse at v=200, then v=480 h=0 → exactly one `swap_ack` pulse, `buf_sel`=1.
   - Then h=0, v=0 → `read_address`=19200.
6. Reset mid-swap: `swap_req`, then `reset` before v=480 → no `swap_ack`, `buf_sel` stays 0.
7. Border (FB_W=100 instance): h=400, v=0 → `pixel_valid`=0, `pixel_out`=BORDER_RGB.
